// File: rtl/fft_pkg.sv
// fft_pkg: shared FSM state type, Q-format constant and index helpers for the radix-2 FFT engine
package fft_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, CALC, UNLOAD} state_t;

    localparam int FRAC_DEFAULT = 16;
    localparam int ONE = 1 << FRAC_DEFAULT;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int unsigned bitrev(input int unsigned k, input int n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < n; i++) r = (r << 1) | ((k >> i) & 1);
        return r;
    endfunction

endpackage

// File: rtl/fft_twiddle_rom.sv
// fft_twiddle_rom: elaboration-time table of W^k for k < N_PTS/2, direction-selected sine sign
module fft_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N_PTS = 8,
    parameter int W     = 32,
    parameter int FRAC  = 16
) (
    input  logic [clog2(N_PTS)-2:0] idx,
    input  logic                    inverse,
    output logic [W-1:0]            cos,
    output logic [W-1:0]            sin
);

    localparam real PI = 3.14159265358979323846;

    logic [W-1:0] ct [N_PTS/2];
    logic [W-1:0] st [N_PTS/2];

    for (genvar i = 0; i < N_PTS/2; i++) begin : g_tw
        localparam real C = $cos(2.0 * PI * i / N_PTS) * 2.0 ** FRAC;
        localparam real S = $sin(2.0 * PI * i / N_PTS) * 2.0 ** FRAC;
        assign ct[i] = W'(C < 0.0 ? -$rtoi(0.5 - C) : $rtoi(C + 0.5));
        assign st[i] = W'(S < 0.0 ? -$rtoi(0.5 - S) : $rtoi(S + 0.5));
    end

    // Forward uses cos - i*sin, inverse cos + i*sin
    assign cos = ct[idx];
    assign sin = inverse ? st[idx] : -st[idx];

endmodule

// File: rtl/fft_r2_engine.sv
// fft_r2_engine: in-place radix-2 DIT FFT/IFFT, streaming load and unload, one butterfly per cycle
module fft_r2_engine
    import fft_pkg::*;
#(
    parameter int N_PTS = 8,
    parameter int W     = 32,
    parameter int FRAC  = 16,
    parameter int SCALE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         inverse,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic         out_last,
    output logic         busy,
    output logic         done
);

    localparam int LOG = clog2(N_PTS);
    localparam int LB  = LOG - 1;
    localparam int W2  = 2 * W;

    state_t state, nxt;
    logic [LOG-1:0] cnt, bf, mask, ia, ib;
    logic [LB-1:0] bfly, k;
    logic [3:0] stg;
    logic inv, last_bf, last_stg, hs_in, hs_out;
    logic [W2-1:0] mem [N_PTS];
    logic signed [W-1:0] ar, ai, br, bi, wr, wi, tr, ti, xr, xi, yr, yi;
    logic signed [W2-1:0] pr, pi;

    function automatic logic signed [W-1:0] sc(input logic signed [W-1:0] v);
        return SCALE != 0 ? v >>> 1 : v;
    endfunction

    assign busy      = state != IDLE;
    assign in_ready  = state == LOAD;
    assign out_valid = state == UNLOAD;
    assign out_last  = out_valid && cnt == '1;
    assign {out_re, out_im} = out_valid ? mem[cnt] : '0;
    assign hs_in     = in_valid && in_ready;
    assign hs_out    = out_valid && out_ready;
    assign last_bf   = bfly == '1;
    assign last_stg  = stg == 4'(LOG - 1);

    fft_twiddle_rom #(.N_PTS(N_PTS), .W(W), .FRAC(FRAC)) u_rom (
        .idx(k),
        .inverse(inv),
        .cos(wr),
        .sin(wi)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nxt;
    end

    // Next-state: frame sequencing
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = (hs_in && cnt == '1) ? CALC : LOAD;
            CALC:    nxt = (last_bf && last_stg) ? UNLOAD : CALC;
            UNLOAD:  nxt = (hs_out && out_last) ? IDLE : UNLOAD;
            default: nxt = IDLE;
        endcase
    end

    // Sample/bin counter, butterfly and stage counters, direction register, done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            bfly <= '0;
            stg  <= '0;
            inv  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= hs_out && out_last;
            if (state == IDLE && start) inv <= inverse;
            if (hs_in || hs_out) cnt <= cnt + 1'b1;
            if (state == CALC) begin
                bfly <= bfly + 1'b1;
                if (last_bf) stg <= last_stg ? '0 : stg + 1'b1;
            end
        end
    end

    // Butterfly operand addresses, twiddle index and complex arithmetic
    always_comb begin
        bf   = {1'b0, bfly};
        mask = (LOG'(1) << stg) - 1'b1;
        ia   = ((bf & ~mask) << 1) | (bf & mask);
        ib   = ia | (mask + 1'b1);
        k    = LB'((bf & mask) << (LB - int'(stg)));
        {ar, ai} = mem[ia];
        {br, bi} = mem[ib];
        pr = W2'(br) * W2'(wr) - W2'(bi) * W2'(wi);
        pi = W2'(br) * W2'(wi) + W2'(bi) * W2'(wr);
        tr = W'(pr >>> FRAC);
        ti = W'(pi >>> FRAC);
        xr = ar + tr;
        xi = ai + ti;
        yr = ar - tr;
        yi = ai - ti;
    end

    // Bit-reversed sample load and in-place butterfly write-back
    always_ff @(posedge clk) begin
        if (hs_in) mem[LOG'(bitrev(32'(cnt), LOG))] <= {in_re, in_im};
        else if (state == CALC) begin
            mem[ia] <= {sc(xr), sc(xi)};
            mem[ib] <= {sc(yr), sc(yi)};
        end
    end

endmodule

// File: tb/tb_fft_r2_engine.sv
// tb_fft_r2_engine: directed frames on unscaled and scaled 8-point engines sharing one stimulus
module tb_fft_r2_engine;

    logic clk = 0, rst = 1, start = 0, inverse = 0, in_valid = 0, out_ready = 0;
    logic [31:0] in_re = 0, in_im = 0;
    logic ir0, ov0, ol0, bz0, dn0, ir1, ov1, ol1, bz1, dn1;
    logic [31:0] r0, i0, r1, i1;
    int nchk = 0, nfail = 0, dn = 0;
    int xr[8], xi[8], e0r[8], e0i[8], e1r[8], e1i[8];
    int sn[8] = '{0, 46341, 65536, 46341, 0, -46341, -65536, -46341};

    always #5 clk = ~clk;

    fft_r2_engine #(.N_PTS(8), .W(32), .FRAC(16), .SCALE(0)) d0 (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .in_valid(in_valid), .in_ready(ir0), .in_re(in_re), .in_im(in_im),
        .out_valid(ov0), .out_ready(out_ready), .out_re(r0), .out_im(i0),
        .out_last(ol0), .busy(bz0), .done(dn0)
    );

    fft_r2_engine #(.N_PTS(8), .W(32), .FRAC(16), .SCALE(1)) d1 (
        .clk(clk), .rst(rst), .start(start), .inverse(inverse),
        .in_valid(in_valid), .in_ready(ir1), .in_re(in_re), .in_im(in_im),
        .out_valid(ov1), .out_ready(out_ready), .out_re(r1), .out_im(i1),
        .out_last(ol1), .busy(bz1), .done(dn1)
    );

    task automatic eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic near(input string tag, input int idx, input logic [31:0] got, input int exp, input int tol);
        int d;
        d = int'($signed(got)) - exp;
        nchk++;
        assert (d >= -tol && d <= tol) else begin
            nfail++;
            $error("FAIL %s[%0d]: got %0d expected %0d tol %0d", tag, idx, $signed(got), exp, tol);
        end
    endtask

    task automatic load(input bit inv, input bit gap);
        int k = 0, cyc = 0;
        start = 1;
        inverse = inv;
        @(posedge clk); #1;
        start = 0;
        inverse = 0;
        eq("in_ready_load", {31'b0, ir0}, 1);
        while (k < 8 && cyc < 200) begin
            in_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (k == 3);
            in_re = xr[k];
            in_im = xi[k];
            @(posedge clk); #1;
            cyc++;
            if (in_valid) k++;
        end
        start = 0;
        in_valid = 1;
        in_re = 32'h7fff_0000;
        in_im = 32'h1234_5678;
        eq("load_count", k, 8);
    endtask

    task automatic calc();
        int cyc = 0;
        while (!ov0 && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        eq("calc_cycles", cyc, 12);
    endtask

    task automatic unload(input bit gap, input int tol);
        int n = 0, cyc = 0, pulses = 0;
        bit stall = 0;
        logic [31:0] hr = 0, hi = 0;
        while (n < 8 && cyc < 200) begin
            out_ready = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            start = (n == 2);
            eq("out_valid", {31'b0, ov0}, 1);
            if (stall) begin
                eq("hold_re", r0, hr);
                eq("hold_im", i0, hi);
            end
            if (out_ready) begin
                near("re_s0", n, r0, e0r[n], tol);
                near("im_s0", n, i0, e0i[n], tol);
                near("re_s1", n, r1, e1r[n], tol);
                near("im_s1", n, i1, e1i[n], tol);
                eq("out_last", {31'b0, ol0}, {31'b0, n == 7});
                n++;
            end
            stall = !out_ready;
            hr = r0;
            hi = i0;
            @(posedge clk); #1;
            cyc++;
            if (dn0) pulses++;
        end
        out_ready = 0;
        start = 0;
        eq("unload_count", n, 8);
        eq("done_once", pulses, 1);
        eq("done_now", {31'b0, dn0}, 1);
        eq("idle_after", {31'b0, bz0}, 0);
        @(posedge clk); #1;
        eq("done_clear", {31'b0, dn0}, 0);
    endtask

    task automatic frame(input bit inv, input bit gap, input int tol);
        load(inv, gap);
        calc();
        unload(gap, tol);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        eq("rst_in_ready", {31'b0, ir0}, 0);
        eq("rst_out_valid", {31'b0, ov0}, 0);
        eq("rst_out_last", {31'b0, ol0}, 0);
        eq("rst_busy", {31'b0, bz0}, 0);
        eq("rst_done", {31'b0, dn0}, 0);
        eq("rst_out_re", r0, 0);
        eq("rst_out_im", i0, 0);
        eq("rst_busy_s1", {31'b0, bz1}, 0);
        rst = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            xr[i] = (i == 0) ? 65536 : 0;
            xi[i] = 0;
            e0r[i] = 65536;
            e0i[i] = 0;
            e1r[i] = 8192;
            e1i[i] = 0;
        end
        frame(0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            xr[i] = 65536;
            e0r[i] = (i == 0) ? 524288 : 0;
            e1r[i] = (i == 0) ? 65536 : 0;
        end
        frame(0, 1, 4);

        for (int i = 0; i < 8; i++) begin
            xr[i] = sn[i];
            e0r[i] = 0;
            e1r[i] = 0;
            e0i[i] = (i == 1) ? -262144 : (i == 7) ? 262144 : 0;
            e1i[i] = (i == 1) ? -32768 : (i == 7) ? 32768 : 0;
        end
        frame(0, 1, 8);

        for (int i = 0; i < 8; i++) begin
            e0i[i] = -e0i[i];
            e1i[i] = -e1i[i];
        end
        frame(1, 1, 8);

        for (int i = 0; i < 8; i++) begin
            xr[i] = (i == 0) ? 524288 : 0;
            e0r[i] = 524288;
            e0i[i] = 0;
            e1r[i] = 65536;
            e1i[i] = 0;
        end
        frame(1, 0, 4);

        load(0, 0);
        repeat (5) @(posedge clk);
        #1;
        eq("mid_calc_busy", {31'b0, bz0}, 1);
        rst = 1;
        #1;
        eq("rst_calc_busy", {31'b0, bz0}, 0);
        eq("rst_calc_valid", {31'b0, ov0}, 0);
        eq("rst_calc_busy_s1", {31'b0, bz1}, 0);
        @(posedge clk); #1;
        rst = 0;
        dn = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dn0 || dn1) dn++;
        end
        eq("no_done_after_rst", dn, 0);
        eq("idle_after_rst", {31'b0, bz0}, 0);

        for (int i = 0; i < 8; i++) begin
            xr[i] = 65536;
            xi[i] = 0;
            e0r[i] = (i == 0) ? 524288 : 0;
            e0i[i] = 0;
            e1r[i] = (i == 0) ? 65536 : 0;
            e1i[i] = 0;
        end
        frame(0, 0, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
